// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS multiply/divide unit with private HI/LO registers
//   clk   - pipeline clock, all state updates on the rising edge
//   reset - asynchronous active-high clear of all state
//   start - qualifies op for an md-class instruction in Execute
//   op    - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no effect
//   a, b  - forwarded rs / rt operands
//   busy  - high while a mult/div is in flight
//   hi,lo - current HI / LO registers
module muldiv_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   logic [4:0]  cnt;
   logic [63:0] pend;
   logic        pend_ok;
   logic        sgn;
   logic [63:0] ae, be, prod;
   logic [31:0] ma, mb, q, r, qs, rs;
   // The result is computed in one shot at start; the counter only models latency.
   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   always_comb begin
      sgn  = ~op[0];
      ae   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      be   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      prod = ae * be;
      ma   = (sgn && a[31]) ? -a : a;
      mb   = (sgn && b[31]) ? -b : b;
      q    = (mb == 32'b0) ? 32'b0 : ma / mb;
      r    = (mb == 32'b0) ? 32'b0 : ma % mb;
      qs   = (sgn && (a[31] ^ b[31])) ? -q : q;
      rs   = (sgn && a[31]) ? -r : r;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         cnt     <= 5'd0;
         pend    <= 64'd0;
         pend_ok <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else if (busy) begin
         cnt <= cnt - 5'd1;
         if (cnt == 5'd1) begin
            busy <= 1'b0;
            // divide by zero leaves HI/LO untouched
            if (pend_ok) {hi, lo} <= pend;
         end
      end else if (start) begin
         if (op[2:1] == 2'b00) begin
            pend    <= prod;
            pend_ok <= 1'b1;
            cnt     <= MULT_CYCLES[4:0];
            busy    <= 1'b1;
         end else if (op[2:1] == 2'b01) begin
            pend    <= {rs, qs};
            pend_ok <= (b != 32'b0);
            cnt     <= DIV_CYCLES[4:0];
            busy    <= 1'b1;
         end else if (op == 3'd4) begin
            hi <= a;
         end else if (op == 3'd5) begin
            lo <= a;
         end
      end
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multiply/divide unit for the pipelined MIPS core, sitting beside the ALU in the Execute stage and consuming the forwarded E-stage operands (`v1_E`, `v2_E`). It executes mult/multu/div/divu as multi-cycle operations into private HI/LO registers, and executes mthi/mtlo in a single cycle. It exports a `busy` flag that the hazard unit uses to stall mult/div/mf/mt instructions in Decode. HI/LO are read combinationally for mfhi/mflo, whose result travels down the pipeline like an ALU result.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (range 1–31).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (range 1–31).

- `clk`  in  1: pipeline clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: qualifies `op`; driven by ControlUnit_E for an md-class instruction in E.
- `op`  in  3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved.
- `a`  in  32: rs operand, forwarded E-stage value.
- `b`  in  32: rt operand, forwarded E-stage value.
- `busy`  out  1: registered; high while an operation is in flight.
- `hi`  out  32: current HI register.
- `lo`  out  32: current LO register.

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, cycle counter=0, pending result=0.
- Idle (`busy`=0) with `start`=1 at an edge:
  - op 0/1: latch the 64-bit product into the pending registers. Signed for op 0, unsigned for op 1. Load counter=`MULT_CYCLES`; `busy`←1.
  - op 2/3: latch the quotient (for LO) and remainder (for HI) into the pending registers. Load counter=`DIV_CYCLES`; `busy`←1.
  - op 4: `hi`←`a`. op 5: `lo`←`a`. Neither sets `busy`.
  - op 6/7: no effect.
- Busy: decrement the counter each edge. At the edge where the counter goes 1→0:
  - `hi`/`lo` ← pending value;
  - `busy`←0.
- The implementation may compute the result combinationally at start or iteratively. Only the observable cycle timing is fixed.
- `start` while `busy`=1 is ignored entirely: no state change, and the in-flight op continues. The hazard unit guarantees this does not occur in normal operation.
- Arithmetic:
  - mult: 32×32 signed, result = {HI,LO}.
  - multu: 32×32 unsigned, result = {HI,LO}.
  - div signed: quotient truncates toward zero; remainder takes the sign of the dividend (`a`).
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div/divu, `b`=0): the op still runs `DIV_CYCLES` with `busy` high, but HI/LO are left unchanged at completion.
- Reset asserted mid-operation aborts the op. Outputs return to their reset values asynchronously, and the pending result is discarded.

## Timing
- Start sampled at edge k. `busy` is high for cycles k+1 … k+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
- At edge k+N: `busy` falls and the new `hi`/`lo` become visible together. No cycle shows `busy`=0 with stale HI/LO after a completed op.
- HI/LO do not change while `busy`=1, so mfhi/mflo must stall. Hazard stall condition for md-class instructions in D: `busy` | (`start` in E).
- mthi/mtlo have zero busy cycles. The written value is visible on `hi`/`lo` in the cycle after the edge.
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0, i.e. cycle k+N+1.

## Test plan
- mult, a=0xFFFFFFFD (−3), b=7 -> `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi/lo hold their old values while busy.
- multu, a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Then mthi a=0x12345678 -> next cycle hi=0x12345678, `busy` stays 0.
- div, a=0xFFFFFFF9 (−7), b=2 -> `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat as divu -> lo=0x7FFFFFFC, hi=0x00000001.
- div, b=0 after preloading hi=0xAAAA0000, lo=0x0000BBBB -> `busy` high 10 cycles, then hi/lo unchanged. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start mult (3×4), then pulse `start` with mtlo a=0xDEAD at busy cycle 2 -> the pulse is ignored; final hi=0, lo=0x0000000C.
- Start div, assert `reset` asynchronously mid-op at busy cycle 4 -> `busy`, hi, lo all 0 immediately. After release, a new mult (2×3) completes normally with lo=6.
